// File: rtl/pipe_stage_skid.sv
`timescale 1ns/1ps
// pipe_stage_skid
//   Pipeline-stage register placed at the core's inter-stage boundaries.
//   The entry is split into a data payload and a control payload. The stage
//   speaks valid/ready with a two-entry skid buffer, so the upstream ready is
//   a flop output and a downstream stall never loses an entry. An invalid
//   stage always shows BUBBLE_DATA (a NOP) and all-zero control. A saturating
//   counter records the cycles in which the stage offered a bubble to a ready
//   consumer.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_flush      synchronous kill of all held entries
//   i_valid      upstream entry valid
//   o_in_ready   stage can accept an entry (registered)
//   i_data       upstream data payload  [DATA_W]
//   i_ctrl       upstream control payload [CTRL_W]
//   o_valid      output entry valid
//   i_out_ready  downstream accepts (0 = stall)
//   o_data       output data payload    [DATA_W]
//   o_ctrl       output control payload [CTRL_W], 0 whenever o_valid = 0
//   i_cnt_clr    synchronous clear of the bubble counter
//   o_bubble_cnt saturating count of bubble cycles [CNT_W]
module pipe_stage_skid #(
    parameter int                DATA_W      = 192,
    parameter int                CTRL_W      = 16,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = {{(DATA_W-32){1'b0}}, 32'h00000013},
    parameter int                CNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // main invalid
        ST_ONE   = 2'd1,   // main valid, skid empty
        ST_TWO   = 2'd2    // main and skid valid
    } state_t;

    // Count up by one, sticking at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_p0, state_nxt;
    logic [DATA_W-1:0]  main_data_p0, main_data_nxt;
    logic [CTRL_W-1:0]  main_ctrl_p0, main_ctrl_nxt;
    logic [DATA_W-1:0]  skid_data_p0, skid_data_nxt;
    logic [CTRL_W-1:0]  skid_ctrl_p0, skid_ctrl_nxt;
    logic               in_ready_p0, in_ready_nxt;
    logic [CNT_W-1:0]   bubble_cnt_p0, bubble_cnt_nxt;
    logic               vld_p0;
    logic               accept;
    logic               drain;

    assign vld_p0 = (state_p0 != ST_EMPTY);
    // in_ready_p0 is low only in ST_TWO, so accept never fires there.
    assign accept = i_valid & in_ready_p0;
    assign drain  = vld_p0 & i_out_ready;

    // Next-state and storage steering
    always_comb begin
        state_nxt     = state_p0;
        main_data_nxt = main_data_p0;
        main_ctrl_nxt = main_ctrl_p0;
        skid_data_nxt = skid_data_p0;
        skid_ctrl_nxt = skid_ctrl_p0;

        if (i_flush) begin
            // A same-cycle drain has already been taken by the consumer;
            // everything else, including a same-cycle accept, is dropped.
            state_nxt     = ST_EMPTY;
            main_data_nxt = BUBBLE_DATA;
            main_ctrl_nxt = '0;
            skid_data_nxt = BUBBLE_DATA;
            skid_ctrl_nxt = '0;
        end else begin
            case (state_p0)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt     = ST_ONE;
                        main_data_nxt = i_data;
                        main_ctrl_nxt = i_ctrl;
                    end else begin
                        main_data_nxt = BUBBLE_DATA;
                        main_ctrl_nxt = '0;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_data_nxt = i_data;
                        main_ctrl_nxt = i_ctrl;
                    end else if (accept) begin
                        state_nxt     = ST_TWO;
                        skid_data_nxt = i_data;
                        skid_ctrl_nxt = i_ctrl;
                    end else if (drain) begin
                        state_nxt     = ST_EMPTY;
                        main_data_nxt = BUBBLE_DATA;
                        main_ctrl_nxt = '0;
                    end
                end
                ST_TWO: begin
                    // Skid entry is younger, so it moves up behind the drained main.
                    if (drain) begin
                        state_nxt     = ST_ONE;
                        main_data_nxt = skid_data_p0;
                        main_ctrl_nxt = skid_ctrl_p0;
                        skid_data_nxt = BUBBLE_DATA;
                        skid_ctrl_nxt = '0;
                    end
                end
                default: begin
                    state_nxt     = ST_EMPTY;
                    main_data_nxt = BUBBLE_DATA;
                    main_ctrl_nxt = '0;
                    skid_data_nxt = BUBBLE_DATA;
                    skid_ctrl_nxt = '0;
                end
            endcase
        end

        // Ready is decided from the next state so it can be a plain flop.
        in_ready_nxt = (state_nxt != ST_TWO);

        if (i_cnt_clr) begin
            bubble_cnt_nxt = '0;
        end else if (!vld_p0 && i_out_ready) begin
            bubble_cnt_nxt = sat_inc(bubble_cnt_p0);
        end else begin
            bubble_cnt_nxt = bubble_cnt_p0;
        end
    end

    // Stage register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_p0      <= ST_EMPTY;
            main_data_p0  <= BUBBLE_DATA;
            main_ctrl_p0  <= '0;
            skid_data_p0  <= BUBBLE_DATA;
            skid_ctrl_p0  <= '0;
            in_ready_p0   <= 1'b1;
            bubble_cnt_p0 <= '0;
        end else begin
            state_p0      <= state_nxt;
            main_data_p0  <= main_data_nxt;
            main_ctrl_p0  <= main_ctrl_nxt;
            skid_data_p0  <= skid_data_nxt;
            skid_ctrl_p0  <= skid_ctrl_nxt;
            in_ready_p0   <= in_ready_nxt;
            bubble_cnt_p0 <= bubble_cnt_nxt;
        end
    end

    assign o_valid      = vld_p0;
    assign o_in_ready   = in_ready_p0;
    assign o_data       = main_data_p0;
    assign o_ctrl       = main_ctrl_p0;
    assign o_bubble_cnt = bubble_cnt_p0;

endmodule

// File: tb/tb_pipe_stage_skid.sv
`timescale 1ns/1ps
module tb_pipe_stage_skid;

    localparam int DW  = 192;
    localparam int CW  = 16;
    localparam int CNT = 4;
    localparam logic [DW-1:0] BUB = {{(DW-32){1'b0}}, 32'h00000013};
    localparam int CNT_MAX = (1 << CNT) - 1;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_flush = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_in_ready;
    logic [DW-1:0] i_data = '0;
    logic [CW-1:0] i_ctrl = '0;
    logic          o_valid;
    logic          i_out_ready = 1'b0;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_ctrl;
    logic          i_cnt_clr = 1'b0;
    logic [CNT-1:0] o_bubble_cnt;

    pipe_stage_skid #(
        .DATA_W(DW), .CTRL_W(CW), .BUBBLE_DATA(BUB), .CNT_W(CNT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(i_flush),
        .i_valid(i_valid), .o_in_ready(o_in_ready),
        .i_data(i_data), .i_ctrl(i_ctrl),
        .o_valid(o_valid), .i_out_ready(i_out_ready),
        .o_data(o_data), .o_ctrl(o_ctrl),
        .i_cnt_clr(i_cnt_clr), .o_bubble_cnt(o_bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the stage is a FIFO of at most two entries.
    entry_t exp_q[$];
    int     held    = 0;
    int     exp_cnt = 0;
    bit     mon_en  = 1'b0;
    int     vectors = 0;
    int     miscompares = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: outputs and inputs are both stable at the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", {255'd0, o_in_ready}, {255'd0, (held < 2)});
            chk("valid", {255'd0, o_valid}, {255'd0, (held > 0)});
            chk("bubble_cnt", {252'd0, o_bubble_cnt}, 256'(exp_cnt));
            if (held > 0) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got ctrl %h expected no entry", o_ctrl);
                end else begin
                    chk("data", {64'd0, o_data}, {64'd0, exp_q[0].d});
                    chk("ctrl", {240'd0, o_ctrl}, {240'd0, exp_q[0].c});
                    if (i_out_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("bubble_ctrl", {240'd0, o_ctrl}, 256'd0);
                chk("bubble_data", {64'd0, o_data}, {64'd0, BUB});
            end
        end
    end

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input bit v, input bit f, input bit r, input bit c,
                        input logic [DW-1:0] d, input logic [CW-1:0] ct);
        bit acc;
        int held_before;
        i_valid = v; i_flush = f; i_out_ready = r; i_cnt_clr = c;
        i_data = d; i_ctrl = ct;
        held_before = held;
        acc = v && (held < 2);
        @(negedge clk);
        #1;
        if (f) exp_q.delete();
        else if (acc) exp_q.push_back('{d: d, c: ct});
        held = exp_q.size();
        if (c) exp_cnt = 0;
        else if (held_before == 0 && r && exp_cnt < CNT_MAX) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, r, 1'b0, rnd_data(), 16'hdead);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] da, db, dc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {255'd0, o_valid}, 256'd0);
        chk("rst_in_ready", {255'd0, o_in_ready}, 256'd1);
        chk("rst_ctrl", {240'd0, o_ctrl}, 256'd0);
        chk("rst_data", {64'd0, o_data}, {64'd0, BUB});
        chk("rst_cnt", {252'd0, o_bubble_cnt}, 256'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Idle with ready high: five bubble cycles.
        idle(5, 1'b1);
        chk("idle_cnt5", {252'd0, o_bubble_cnt}, 256'd5);
        chk("idle_low32", {224'd0, o_data[31:0]}, 256'h13);
        step(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);

        // Back-to-back stream of four entries.
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, rnd_data(), CW'(i));
            chk("stream_valid", {255'd0, o_valid}, 256'd1);
            chk("stream_ctrl", {240'd0, o_ctrl}, 256'(i));
        end
        idle(2, 1'b1);

        // Stall: A in main, B into skid, C held upstream.
        da = rnd_data(); db = rnd_data(); dc = rnd_data();
        step(1'b1, 1'b0, 1'b0, 1'b0, da, 16'h00a0);
        step(1'b1, 1'b0, 1'b0, 1'b0, db, 16'h00b0);
        chk("skid_in_ready", {255'd0, o_in_ready}, 256'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, dc, 16'h00c0);
        chk("stall_hold", {240'd0, o_ctrl}, 256'h00a0);
        step(1'b1, 1'b0, 1'b1, 1'b0, dc, 16'h00c0);
        step(1'b1, 1'b0, 1'b1, 1'b0, dc, 16'h00c0);
        idle(3, 1'b1);

        // Flush from TWO with a simultaneous offer.
        step(1'b1, 1'b0, 1'b0, 1'b0, rnd_data(), 16'h0111);
        step(1'b1, 1'b0, 1'b0, 1'b0, rnd_data(), 16'h0222);
        step(1'b1, 1'b1, 1'b0, 1'b0, rnd_data(), 16'h0333);
        chk("flush_valid", {255'd0, o_valid}, 256'd0);
        chk("flush_ctrl", {240'd0, o_ctrl}, 256'd0);
        chk("flush_in_ready", {255'd0, o_in_ready}, 256'd1);
        idle(2, 1'b1);

        // Counter saturation and clear.
        step(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        idle(20, 1'b1);
        chk("cnt_sat", {252'd0, o_bubble_cnt}, 256'(CNT_MAX));
        step(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        chk("cnt_clr", {252'd0, o_bubble_cnt}, 256'd0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 29) == 0),
                 rnd_data(), CW'($urandom));
        end

        // Asynchronous reset mid-cycle while holding one stalled entry.
        idle(3, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, rnd_data(), 16'h0777);
        i_valid = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        held = 0;
        exp_cnt = 0;
        #1;
        chk("arst_valid", {255'd0, o_valid}, 256'd0);
        chk("arst_ctrl", {240'd0, o_ctrl}, 256'd0);
        chk("arst_data", {64'd0, o_data}, {64'd0, BUB});
        chk("arst_in_ready", {255'd0, o_in_ready}, 256'd1);
        chk("arst_cnt", {252'd0, o_bubble_cnt}, 256'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First accept on the first edge after release.
        step(1'b1, 1'b0, 1'b1, 1'b0, rnd_data(), 16'h0999);
        chk("post_rst_valid", {255'd0, o_valid}, 256'd1);
        idle(4, 1'b1);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register for the core's inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generalises the fixed-field stage register into a payload/control split with bubble masking.
- Adds a valid/ready handshake with a 2-entry skid buffer, so upstream ready is registered and a downstream stall never drops an instruction.
- Supports synchronous flush and includes a saturating bubble counter for performance monitoring.

Parameters:
DATA_W, 192, width of the data payload (pc, pc+4, operands, immediate, instruction, register addresses packed by the instantiating stage)
CTRL_W, 16, width of the control payload; forced to zero whenever the stage holds a bubble
BUBBLE_DATA, {DATA_W{1'b0}} with low 32 bits = 32'h00000013, data value presented while the stage holds a bubble (NOP in the instruction field)
CNT_W, 16, width of the bubble counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_flush  in  1  synchronous kill of all held entries; inserts a bubble
i_valid  in  1  upstream entry valid
o_in_ready  out  1  stage can accept an entry; registered
i_data  in  DATA_W  upstream data payload
i_ctrl  in  CTRL_W  upstream control payload
o_valid  out  1  output entry valid
i_out_ready  in  1  downstream accepts (0 = stall)
o_data  out  DATA_W  output data payload
o_ctrl  out  CTRL_W  output control payload; 0 whenever o_valid=0
i_cnt_clr  in  1  synchronous clear of bubble counter
o_bubble_cnt  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Handshake: accept = i_valid & o_in_ready; drain = o_valid & i_out_ready.
- Storage: a main register (drives outputs) and a skid register. The three states are EMPTY (main invalid), ONE (main valid, skid empty) and TWO (both valid).
- o_in_ready = (state != TWO). It is a register output with no combinational path from i_out_ready.
- Transitions without flush:
  - EMPTY & accept -> ONE, main <= input.
  - ONE & accept & drain -> ONE, main <= input.
  - ONE & accept & !drain -> TWO, skid <= input.
  - ONE & !accept & drain -> EMPTY.
  - TWO & drain -> ONE, main <= skid.
  - In all other cases the state and registers hold.
- Ordering: FIFO order is preserved, so the skid entry always leaves after the main entry.
- Latency: 1 cycle from accept to o_valid when EMPTY. Throughput is 1 entry/cycle while i_out_ready=1.
- Bubble contents: whenever main becomes or stays invalid, o_ctrl <= 0 and o_data <= BUBBLE_DATA. An invalid stage therefore never presents stale control (no reg_write or mem_write).
- Stall: while main is valid and i_out_ready=0, o_data and o_ctrl are held bit-stable.
- Flush: i_flush=1 moves the stage to EMPTY next cycle from any state, and o_in_ready=1 next cycle.
  - Both the main and skid entries are discarded.
  - Any accept occurring in the same cycle is discarded.
  - A drain in the same cycle still counts as delivered downstream.
- Priority: reset > flush > normal operation.
- Bubble counter:
  - Increments by 1 each cycle with o_valid=0 & i_out_ready=1 & i_rst=0.
  - Saturates at 2^CNT_W-1, with no wrap.
  - i_cnt_clr=1 loads 0 and takes priority over increment.
  - i_cnt_clr is independent of i_flush.
- Reset (async, any time, including mid-transfer or in TWO):
  - state = EMPTY, o_valid = 0, o_in_ready = 1.
  - o_data = BUBBLE_DATA, o_ctrl = 0, skid cleared, o_bubble_cnt = 0.
- After reset release: the first accept may occur in the first clock edge with i_rst=0.
- Width rule: payloads pass through unmodified; no arithmetic on data.

Test Plan:
- Reset then idle with i_out_ready=1 for 5 cycles -> o_valid=0, o_ctrl=0, o_data[31:0]=32'h00000013, o_bubble_cnt=5.
- Stream 4 entries (ctrl=16'h0001..0004) with i_out_ready=1 -> each appears 1 cycle after accept, in order, with o_in_ready=1 throughout.
- Accept A, hold i_out_ready=0, offer B then C -> B enters skid, o_in_ready drops to 0, C is held upstream. Release ready -> outputs A, B, C in order with no loss or duplicate.
- In state TWO, assert i_flush with i_valid=1 -> next cycle o_valid=0, o_ctrl=0, o_in_ready=1, and the flushed and offered entries never appear.
- CNT_W=4, 20 bubble cycles -> o_bubble_cnt saturates at 15. Pulse i_cnt_clr -> count 0 next cycle.
- Assert i_rst asynchronously mid-cycle while in ONE with i_out_ready=0 -> outputs immediately show reset values without waiting for a clock edge.
